// File: rtl/fp13_pkg.sv
// Shared types and constants for the 13-bit float format {sign, exp[3:0], frac[7:0]}.
// The value is 0.frac x 2^exp; a nonzero value always has frac[7]=1.
package fp13_pkg;
   localparam int EXP_W  = 4;
   localparam int FRAC_W = 8;
   localparam int FP_W   = 1 + EXP_W + FRAC_W;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp13_t;

   typedef enum logic [1:0] {IDLE, NORM, DONE} conv_state_t;

   localparam fp13_t FP13_ZERO    = '0;
   localparam fp13_t FP13_NEG_SAT = '{sign: 1'b1, exp: '1, frac: '1};
endpackage

// File: rtl/int_abs_sign.sv
// Splits a two's-complement integer into sign, magnitude (below the top bit) and
// zero/saturation flags; sat is set only for the most negative value.
module int_abs_sign #(
   parameter int INT_W = 16
) (
   input  logic [INT_W-1:0] in_int,
   output logic             sign,
   output logic [INT_W-2:0] mag,
   output logic             zero,
   output logic             sat
);
   logic [INT_W-1:0] full_mag;

   assign sign     = in_int[INT_W-1];
   assign full_mag = sign ? (~in_int + INT_W'(1)) : in_int;
   assign mag      = full_mag[INT_W-2:0];
   assign zero     = (full_mag == '0);
   assign sat      = full_mag[INT_W-1];
endmodule

// File: rtl/int_to_fp13_converter.sv
// Signed integer to fp13 converter: latches the operand, normalises it one bit
// per cycle by left shifts, then holds the truncated result until accepted.
module int_to_fp13_converter
   import fp13_pkg::*;
#(
   parameter int INT_W  = 2 ** fp13_pkg::EXP_W,
   parameter int EXP_W  = fp13_pkg::EXP_W,
   parameter int FRAC_W = fp13_pkg::FRAC_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [INT_W-1:0]        in_int,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [EXP_W+FRAC_W:0]   out_float,
   output logic                    out_inexact
);
   localparam int OUT_W = 1 + EXP_W + FRAC_W;

   conv_state_t       state, state_n;
   logic              live_r;
   logic              sign_r, sign_n;
   logic [EXP_W-1:0]  exp_r, exp_n;
   logic [INT_W-2:0]  shreg, shreg_n;
   logic              zero_r, zero_n;
   logic              sat_r, sat_n;
   logic [OUT_W-1:0]  float_r, float_n;
   logic              inx_r, inx_n;

   logic              a_sign, a_zero, a_sat;
   logic [INT_W-2:0]  a_mag;

   int_abs_sign #(.INT_W(INT_W)) u_abs (
      .in_int (in_int),
      .sign   (a_sign),
      .mag    (a_mag),
      .zero   (a_zero),
      .sat    (a_sat)
   );

   // live_r keeps in_ready low during reset and for the edge it is released on
   assign in_ready    = (state == IDLE) && live_r;
   assign out_valid   = (state == DONE);
   assign out_float   = float_r;
   assign out_inexact = inx_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         live_r  <= 1'b0;
         sign_r  <= 1'b0;
         exp_r   <= '0;
         shreg   <= '0;
         zero_r  <= 1'b0;
         sat_r   <= 1'b0;
         float_r <= '0;
         inx_r   <= 1'b0;
      end else begin
         state   <= state_n;
         live_r  <= 1'b1;
         sign_r  <= sign_n;
         exp_r   <= exp_n;
         shreg   <= shreg_n;
         zero_r  <= zero_n;
         sat_r   <= sat_n;
         float_r <= float_n;
         inx_r   <= inx_n;
      end
   end

   always_comb begin
      state_n = state;
      sign_n  = sign_r;
      exp_n   = exp_r;
      shreg_n = shreg;
      zero_n  = zero_r;
      sat_n   = sat_r;
      float_n = float_r;
      inx_n   = inx_r;
      case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               sign_n  = a_sign;
               exp_n   = '1;
               shreg_n = a_mag;
               zero_n  = a_zero;
               sat_n   = a_sat;
               state_n = NORM;
            end
         end
         NORM: begin
            if (zero_r) begin
               float_n = '0;
               inx_n   = 1'b0;
               state_n = DONE;
            end else if (sat_r) begin
               float_n = {1'b1, {EXP_W{1'b1}}, {FRAC_W{1'b1}}};
               inx_n   = 1'b1;
               state_n = DONE;
            end else if (shreg[INT_W-2]) begin
               float_n = {sign_r, exp_r, shreg[INT_W-2 -: FRAC_W]};
               // bits below the fraction survive the shift only if they are nonzero
               inx_n   = ((shreg << FRAC_W) != '0);
               state_n = DONE;
            end else begin
               shreg_n = shreg << 1;
               exp_n   = exp_r - EXP_W'(1);
            end
         end
         DONE: begin
            if (out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_int_to_fp13_converter.sv
// Directed bench for int_to_fp13_converter with an arithmetic reference model.
module tb_int_to_fp13_converter;
   import fp13_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_int;
   logic        out_valid;
   logic        out_ready;
   logic [12:0] out_float;
   logic        out_inexact;

   int nvec = 0;
   int nerr = 0;
   logic [13:0] q[$];

   always #5 clk = ~clk;

   int_to_fp13_converter #(.INT_W(16), .EXP_W(4), .FRAC_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_int      (in_int),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_float   (out_float),
      .out_inexact (out_inexact)
   );

   // returns {inexact, float}; lat = edges from accept to out_valid
   function automatic logic [13:0] model(input logic [15:0] v, output int lat);
      int iv, mag, e, frac;
      logic s, x;
      iv  = int'($signed(v));
      s   = (iv < 0);
      mag = s ? -iv : iv;
      if (mag == 0) begin lat = 1; return 14'h0; end
      if (mag == 32768) begin lat = 1; return {1'b1, FP13_NEG_SAT}; end
      e = 0;
      while ((mag >> e) != 0) e++;
      lat = 16 - e;
      if (e >= 8) begin
         frac = mag >> (e - 8);
         x    = (mag % (1 << (e - 8))) != 0;
      end else begin
         frac = mag << (8 - e);
         x    = 1'b0;
      end
      return {x, s, 4'(e), 8'(frac)};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      nvec++;
      if (got !== want) begin
         nerr++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid) begin
         nvec++;
         if (q.size() == 0) begin
            nerr++;
            $display("FAIL unexpected_result: got %h with nothing pending", {out_inexact, out_float});
         end else begin
            if ({out_inexact, out_float} !== q[0]) begin
               nerr++;
               $display("FAIL result: got %h want %h", {out_inexact, out_float}, q[0]);
            end
            if (out_ready) void'(q.pop_front());
         end
         if (in_ready) begin
            nerr++;
            $display("FAIL ready_in_done: got in_ready=1 want 0");
         end
      end
   end

   task automatic convert(input logic [15:0] v, input logic [12:0] lit_f, input logic lit_x,
                          input int lit_lat, input int hold);
      logic [13:0] m;
      int mlat, n;
      logic busy_ready;
      m = model(v, mlat);
      chk("model_value", 32'(m), 32'({lit_x, lit_f}));
      chk("model_latency", 32'(mlat), 32'(lit_lat));
      out_ready = (hold == 0);
      n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      chk("wait_in_ready", 32'(in_ready), 32'(1));
      in_int   = v;
      in_valid = 1'b1;
      q.push_back(m);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_int   = 16'($urandom);
      n = 0;
      busy_ready = 1'b0;
      while (!out_valid && n < 40) begin
         if (in_ready) busy_ready = 1'b1;
         @(posedge clk); #1;
         n++;
      end
      chk("latency", 32'(n), 32'(mlat));
      chk("in_ready_busy", 32'(busy_ready), 32'(0));
      repeat (hold) begin
         in_valid = 1'($urandom);
         in_int   = 16'($urandom);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("release_valid", 32'(out_valid), 32'(0));
      chk("release_ready", 32'(in_ready), 32'(1));
      @(posedge clk); #1;
      chk("idle_valid", 32'(out_valid), 32'(0));
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_int = '0;
      #23;
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_in_ready", 32'(in_ready), 32'(0));
      chk("rst_out_float", 32'(out_float), 32'(0));
      chk("rst_out_inexact", 32'(out_inexact), 32'(0));
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'(1));

      convert(16'd1,      13'h0180, 1'b0, 15, 0);
      convert(-16'sd5,    13'h13A0, 1'b0, 13, 0);
      convert(16'd301,    13'h0996, 1'b1,  7, 0);
      convert(16'd32767,  13'h0FFF, 1'b1,  1, 0);
      convert(16'h8000,   13'h1FFF, 1'b1,  1, 0);
      convert(16'd0,      13'h0000, 1'b0,  1, 0);
      convert(16'hFFFF,   13'h1180, 1'b0, 15, 0);
      convert(16'd12345,  13'h0EC0, 1'b1,  2, 0);
      convert(-16'sd256,  13'h1980, 1'b0,  7, 0);
      convert(-16'sd5,    13'h13A0, 1'b0, 13, 20);

      // abort a conversion of 1 mid-normalisation
      out_ready = 1'b1;
      in_int = 16'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("abort_out_valid", 32'(out_valid), 32'(0));
      chk("abort_in_ready", 32'(in_ready), 32'(0));
      q.delete();
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      convert(16'd2,      13'h0280, 1'b0, 14, 0);
      convert(16'd0,      13'h0000, 1'b0,  1, 0);

      chk("queue_drained", 32'(q.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/int_to_fp13_converter.md
Name: int_to_fp13_converter

Overview:
Sequential converter from a signed two's-complement integer to the team's 13-bit floating-point format: sign[12], exponent[11:8], fraction[7:0]. The value is 0.fraction × 2^exponent, and a nonzero result has fraction[7]=1. It produces operands for the float compare/arith datapath. Input and output use valid/ready handshakes. Normalisation uses a one-bit-per-cycle left-shift FSM, so latency depends on the data.

Parameters:
INT_W, 16, input integer width; must equal 2**EXP_W
EXP_W, 4, exponent field width
FRAC_W, 8, fraction field width; must be ≤ INT_W-1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  in_int is valid
in_ready  out  1  converter can accept; high only in IDLE
in_int  in  INT_W  signed two's-complement operand
out_valid  out  1  out_float/out_inexact valid; held until accepted
out_ready  in  1  downstream accepts result
out_float  out  1+EXP_W+FRAC_W  {sign, exp, frac}
out_inexact  out  1  nonzero bits were truncated, or result saturated

Behaviour:
- Reset (async, immediate): state=IDLE, out_valid=0, out_float=0, out_inexact=0, internal regs=0. in_ready=1 from the next cycle after rst deasserts; in_ready=0 while rst is high.
- States: IDLE, NORM, DONE. in_ready=(state==IDLE). out_valid=(state==DONE).
- IDLE:
  - On in_valid&&in_ready, latch sign=in_int[INT_W-1] and mag=|in_int| (INT_W bits).
  - Load exp=2**EXP_W-1 and shreg=mag[INT_W-2:0].
  - Set flags zero=(mag==0) and sat=mag[INT_W-1]; sat is true only for the most negative value.
  - Go to NORM.
- NORM, evaluated each cycle in this priority:
  - zero: out_float=0 (sign forced 0), inexact=0, go to DONE.
  - sat: out_float={1, all-ones exp, all-ones frac}, inexact=1, go to DONE.
  - shreg MSB=1: frac=shreg[INT_W-2 -: FRAC_W], inexact=|shreg[remaining low bits], go to DONE.
  - Otherwise: shreg<<=1 (zero fill), exp-=1, stay in NORM.
  - Exp never underflows: a nonzero mag has lz ≤ INT_W-2, so the minimum exp is 1.
- Latency: out_valid rises lz+1 clock edges after the accept edge, where lz = leading zeros of the (INT_W-1)-bit shreg. Special cases (zero, saturation) take 1 edge. Maximum is INT_W-1 edges.
- DONE:
  - out_float and out_inexact are stable and registered.
  - On out_ready=1, go to IDLE; out_valid falls the next cycle.
  - out_ready=0 holds indefinitely; no new input is accepted.
- Throughput: at most one conversion in flight. in_valid during NORM/DONE is ignored and not latched.
- Rounding is truncation toward zero on magnitude. Sign is preserved except for zero.
- rst mid-NORM or mid-DONE aborts the conversion; the result is discarded and out_valid drops immediately.
- in_int changing after the accept edge has no effect.
- out_ready high while not in DONE has no effect.

Decomposition:
- Package fp13_pkg:
  - EXP_W, FRAC_W, FP_W constants.
  - typedef struct packed {logic sign; logic [EXP_W-1:0] exp; logic [FRAC_W-1:0] frac;} fp13_t.
  - FSM enum conv_state_t {IDLE, NORM, DONE}.
  - FP13_ZERO and FP13_NEG_SAT constants.
- The FSM, shift register and exponent counter live in a single module.
- One optional combinational sub-module, int_abs_sign, splits in_int into sign, magnitude and the zero/sat flags.

Test Plan:
1. in_int=1, out_ready=1 → after 15 edges out_float=0_0001_10000000, inexact=0; in_ready low throughout.
2. in_int=-5 → out_float=1_0011_10100000 after 13 edges. in_int=301 → 0_1001_10010110 (=300), inexact=1.
3. in_int=32767 → 0_1111_11111111 after 1 edge. in_int=-32768 → 1_1111_11111111, inexact=1, 1 edge.
4. in_int=0, and in_int=0 with negative-zero inputs → 0_0000_00000000, inexact=0, sign 0.
5. Backpressure: out_ready=0 for 20 cycles after out_valid → out_float is stable; in_valid pulses are ignored. Raising out_ready gives exactly one handshake, then IDLE.
6. Assert rst mid-NORM (in_int=1, after 5 edges) → out_valid=0 immediately. After release, a new in_int=2 yields 0_0010_10000000 with no residue from the aborted conversion.
